// File: rtl/hand_slot_allocator_if.sv
// Player/game-control side bundle for the hand slot allocator.
// The master modport is the game-control side, the slave modport is the allocator.
interface hand_slot_allocator_if #(
    parameter int NUM_PLAYERS = 4,
    parameter int ADDR_W      = 10,
    parameter int CNT_W       = 4
);
    logic [NUM_PLAYERS-1:0]        alloc_req;
    logic [NUM_PLAYERS-1:0]        release_req;
    logic [NUM_PLAYERS-1:0]        adr_found;
    logic [NUM_PLAYERS*ADDR_W-1:0] address;
    logic [NUM_PLAYERS-1:0]        hand_valid;
    logic [NUM_PLAYERS-1:0]        alloc_fail;
    logic [CNT_W-1:0]              free_count;
    logic                          busy;

    modport master (
        output alloc_req, release_req,
        input  adr_found, address, hand_valid, alloc_fail, free_count, busy
    );

    modport slave (
        input  alloc_req, release_req,
        output adr_found, address, hand_valid, alloc_fail, free_count, busy
    );
endinterface

// File: rtl/hand_slot_allocator.sv
// Round-robin allocator handing fixed-size hand regions of card memory to players.
// A granted request scans the slot pool one slot per cycle; releases apply in any state.
module hand_slot_allocator #(
    parameter int NUM_PLAYERS = 4,
    parameter int NUM_SLOTS   = 8,
    parameter int ADDR_W      = 10,
    parameter int SLOT_STRIDE = 16,
    parameter int BASE_ADDR   = 0
) (
    input  logic                 clock,
    input  logic                 reset,
    hand_slot_allocator_if.slave bus
);
    localparam int PW = $clog2(NUM_PLAYERS);
    localparam int SW = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
    localparam int CW = $clog2(NUM_SLOTS + 1);

    typedef enum logic {ST_IDLE, ST_SCAN} state_t;

    state_t                 state_q;
    logic [PW-1:0]          rr_ptr_q;
    logic [PW-1:0]          cur_q;
    logic [SW-1:0]          scan_idx_q;
    logic [NUM_SLOTS-1:0]   free_q;
    logic [SW-1:0]          slot_q [NUM_PLAYERS];
    logic [ADDR_W-1:0]      addr_q [NUM_PLAYERS];
    logic [NUM_PLAYERS-1:0] hand_valid_q;
    logic [NUM_PLAYERS-1:0] adr_found_q;
    logic [NUM_PLAYERS-1:0] alloc_fail_q;
    logic [CW-1:0]          free_count_q;

    logic [NUM_PLAYERS-1:0] eligible_d;
    logic [NUM_PLAYERS-1:0] rel_ok_d;
    logic                   pick_vld_d;
    logic [PW-1:0]          pick_idx_d;
    logic [PW:0]            cand_d;
    logic [CW-1:0]          rel_cnt_d;
    logic                   grant_d;
    logic                   last_slot_d;

    function automatic logic [ADDR_W-1:0] slot_addr(input logic [SW-1:0] idx);
        logic [31:0] a;
        a = 32'(BASE_ADDR) + 32'(idx) * 32'(SLOT_STRIDE);
        return a[ADDR_W-1:0];
    endfunction

    function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] v);
        return (v == PW'(NUM_PLAYERS - 1)) ? '0 : v + 1'b1;
    endfunction

    // Arbitration: first eligible player at or after rr_ptr, wrapping.
    always_comb begin
        eligible_d = bus.alloc_req & ~hand_valid_q;
        rel_ok_d   = bus.release_req & hand_valid_q;
        pick_vld_d = 1'b0;
        pick_idx_d = '0;
        cand_d     = '0;
        rel_cnt_d  = '0;
        for (int i = 0; i < NUM_PLAYERS; i++) begin
            cand_d = {1'b0, rr_ptr_q} + (PW+1)'(i);
            if (cand_d >= (PW+1)'(NUM_PLAYERS)) cand_d = cand_d - (PW+1)'(NUM_PLAYERS);
            if (!pick_vld_d && eligible_d[cand_d[PW-1:0]]) begin
                pick_vld_d = 1'b1;
                pick_idx_d = cand_d[PW-1:0];
            end
        end
        for (int p = 0; p < NUM_PLAYERS; p++) rel_cnt_d = rel_cnt_d + CW'(rel_ok_d[p]);
        grant_d     = (state_q == ST_SCAN) && free_q[scan_idx_q];
        last_slot_d = (scan_idx_q == SW'(NUM_SLOTS - 1));
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            rr_ptr_q     <= '0;
            cur_q        <= '0;
            scan_idx_q   <= '0;
            free_q       <= '1;
            slot_q       <= '{default: '0};
            addr_q       <= '{default: '0};
            hand_valid_q <= '0;
            adr_found_q  <= '0;
            alloc_fail_q <= '0;
            free_count_q <= CW'(NUM_SLOTS);
        end else begin
            adr_found_q  <= '0;
            alloc_fail_q <= '0;
            free_count_q <= free_count_q - CW'(grant_d) + rel_cnt_d;
            // A released slot never coincides with the slot being granted: one is used, the other free.
            for (int p = 0; p < NUM_PLAYERS; p++) begin
                if (rel_ok_d[p]) begin
                    free_q[slot_q[p]] <= 1'b1;
                    hand_valid_q[p]   <= 1'b0;
                    addr_q[p]         <= '0;
                end
            end
            case (state_q)
                ST_IDLE: begin
                    if (pick_vld_d) begin
                        cur_q      <= pick_idx_d;
                        scan_idx_q <= '0;
                        state_q    <= ST_SCAN;
                    end
                end
                ST_SCAN: begin
                    if (grant_d) begin
                        free_q[scan_idx_q]  <= 1'b0;
                        slot_q[cur_q]       <= scan_idx_q;
                        addr_q[cur_q]       <= slot_addr(scan_idx_q);
                        hand_valid_q[cur_q] <= 1'b1;
                        adr_found_q[cur_q]  <= 1'b1;
                        rr_ptr_q            <= wrap_inc(cur_q);
                        state_q             <= ST_IDLE;
                    end else if (last_slot_d) begin
                        alloc_fail_q[cur_q] <= 1'b1;
                        rr_ptr_q            <= wrap_inc(cur_q);
                        state_q             <= ST_IDLE;
                    end else begin
                        scan_idx_q <= scan_idx_q + 1'b1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    for (genvar g = 0; g < NUM_PLAYERS; g++) begin : g_addr
        assign bus.address[g*ADDR_W +: ADDR_W] = addr_q[g];
    end

    assign bus.adr_found  = adr_found_q;
    assign bus.alloc_fail = alloc_fail_q;
    assign bus.hand_valid = hand_valid_q;
    assign bus.free_count = free_count_q;
    assign bus.busy       = (state_q == ST_SCAN);
endmodule

// File: tb/tb_hand_slot_allocator.sv
// Directed bench: an 8-slot allocator (bus_a) and a 2-slot allocator (bus_b) for pool exhaustion.
module tb_hand_slot_allocator;
    logic clk   = 1'b0;
    logic reset = 1'b1;
    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    hand_slot_allocator_if #(.NUM_PLAYERS(4), .ADDR_W(10), .CNT_W(4)) bus_a ();
    hand_slot_allocator_if #(.NUM_PLAYERS(4), .ADDR_W(10), .CNT_W(2)) bus_b ();

    hand_slot_allocator #(.NUM_PLAYERS(4), .NUM_SLOTS(8), .ADDR_W(10),
                          .SLOT_STRIDE(16), .BASE_ADDR(0)) dut_a (
        .clock(clk), .reset(reset), .bus(bus_a)
    );

    hand_slot_allocator #(.NUM_PLAYERS(4), .NUM_SLOTS(2), .ADDR_W(10),
                          .SLOT_STRIDE(16), .BASE_ADDR(0)) dut_b (
        .clock(clk), .reset(reset), .bus(bus_b)
    );

    task automatic step();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] af(input bit b);
        return b ? 32'(bus_b.adr_found) : 32'(bus_a.adr_found);
    endfunction
    function automatic logic [31:0] fl(input bit b);
        return b ? 32'(bus_b.alloc_fail) : 32'(bus_a.alloc_fail);
    endfunction
    function automatic logic [31:0] hv(input bit b);
        return b ? 32'(bus_b.hand_valid) : 32'(bus_a.hand_valid);
    endfunction
    function automatic logic [31:0] fc(input bit b);
        return b ? 32'(bus_b.free_count) : 32'(bus_a.free_count);
    endfunction
    function automatic logic [31:0] bz(input bit b);
        return b ? 32'(bus_b.busy) : 32'(bus_a.busy);
    endfunction
    function automatic logic [31:0] addr(input bit b, input int p);
        return b ? 32'(bus_b.address[p*10 +: 10]) : 32'(bus_a.address[p*10 +: 10]);
    endfunction

    task automatic do_reset();
        reset = 1'b1;
        bus_a.alloc_req = '0; bus_a.release_req = '0;
        bus_b.alloc_req = '0; bus_b.release_req = '0;
        step(); step();
        reset = 1'b0;
    endtask

    // n = number of rising edges from now until the grant is visible.
    task automatic run_to_grant(input bit b, input int n, input int p, input int a, input int fc_exp);
        repeat (n - 1) step();
        chk("pre_grant_quiet", af(b), 0);
        step();
        chk("grant_pulse", af(b), 32'(1 << p));
        chk("grant_addr", addr(b, p), 32'(a));
        chk("grant_hand_valid", (hv(b) >> p) & 1, 1);
        chk("grant_free_count", fc(b), 32'(fc_exp));
        chk("grant_busy_low", bz(b), 0);
        chk("grant_no_fail", fl(b), 0);
    endtask

    task automatic run_to_fail(input bit b, input int n, input int p);
        repeat (n - 1) step();
        chk("pre_fail_quiet", fl(b), 0);
        step();
        chk("fail_pulse", fl(b), 32'(1 << p));
        chk("fail_no_grant", af(b), 0);
        chk("fail_hand_valid", (hv(b) >> p) & 1, 0);
    endtask

    initial begin
        bus_a.alloc_req = '0; bus_a.release_req = '0;
        bus_b.alloc_req = '0; bus_b.release_req = '0;

        // Reset state and single request from player 0
        do_reset();
        chk("rst_adr_found", af(0), 0);
        chk("rst_alloc_fail", fl(0), 0);
        chk("rst_hand_valid", hv(0), 0);
        chk("rst_free_count", fc(0), 8);
        chk("rst_busy", bz(0), 0);
        for (int p = 0; p < 4; p++) chk("rst_addr", addr(0, p), 0);
        bus_a.alloc_req = 4'b0001;
        step();
        chk("t1_busy_scan", bz(0), 1);
        chk("t1_no_early_grant", af(0), 0);
        step();
        chk("t1_grant", af(0), 1);
        chk("t1_addr0", addr(0, 0), 0);
        chk("t1_hand_valid", hv(0), 1);
        chk("t1_free_count", fc(0), 7);
        chk("t1_busy_done", bz(0), 0);
        bus_a.alloc_req = '0;
        step();
        chk("t1_single_pulse", af(0), 0);

        // All four players request together
        do_reset();
        bus_a.alloc_req = 4'b1111;
        run_to_grant(0, 2, 0, 0, 7);
        run_to_grant(0, 3, 1, 16, 6);
        run_to_grant(0, 4, 2, 32, 5);
        run_to_grant(0, 5, 3, 48, 4);
        step();
        chk("t2_holders_ignored", af(0), 0);
        chk("t2_idle", bz(0), 0);
        chk("t2_all_valid", hv(0), 4'b1111);
        bus_a.alloc_req = '0;

        // Release player 1 and reallocate its slot
        bus_a.release_req = 4'b0010;
        step();
        bus_a.release_req = '0;
        chk("t3_rel_free_count", fc(0), 5);
        chk("t3_rel_hand_valid", hv(0), 4'b1101);
        chk("t3_rel_addr1", addr(0, 1), 0);
        bus_a.alloc_req = 4'b0010;
        run_to_grant(0, 3, 1, 16, 4);
        bus_a.alloc_req = '0;

        // Round robin: rr_ptr is 2, so player 3 beats player 0
        bus_a.release_req = 4'b1001;
        step();
        bus_a.release_req = '0;
        chk("t5_rel_free_count", fc(0), 6);
        chk("t5_rel_hand_valid", hv(0), 4'b0110);
        bus_a.alloc_req = 4'b1001;
        run_to_grant(0, 2, 3, 0, 5);
        chk("t5_p0_waiting", hv(0) & 1, 0);
        bus_a.alloc_req = 4'b0001;
        run_to_grant(0, 5, 0, 48, 4);
        bus_a.alloc_req = '0;

        // Reset during a scan with two slots allocated
        do_reset();
        bus_a.alloc_req = 4'b0011;
        run_to_grant(0, 2, 0, 0, 7);
        run_to_grant(0, 3, 1, 16, 6);
        bus_a.alloc_req = 4'b0100;
        step();
        chk("t6_scanning", bz(0), 1);
        reset = 1'b1;
        step();
        chk("t6_rst_no_grant", af(0), 0);
        chk("t6_rst_no_fail", fl(0), 0);
        chk("t6_rst_free_count", fc(0), 8);
        chk("t6_rst_hand_valid", hv(0), 0);
        chk("t6_rst_busy", bz(0), 0);
        for (int p = 0; p < 4; p++) chk("t6_rst_addr", addr(0, p), 0);
        reset = 1'b0;
        run_to_grant(0, 2, 2, 0, 7);
        bus_a.alloc_req = '0;

        // Pool exhaustion on the 2-slot allocator
        bus_b.alloc_req = 4'b0011;
        run_to_grant(1, 2, 0, 0, 1);
        run_to_grant(1, 3, 1, 16, 0);
        bus_b.alloc_req = 4'b0100;
        run_to_fail(1, 3, 2);
        chk("t4_fail_free_count", fc(1), 0);
        run_to_fail(1, 3, 2);
        bus_b.release_req = 4'b0001;
        step();
        bus_b.release_req = '0;
        chk("t4_rel_hand_valid", hv(1), 4'b0010);
        chk("t4_rel_addr0", addr(1, 0), 0);
        chk("t4_rel_free_count", fc(1), 1);
        chk("t4_rescan_busy", bz(1), 1);
        run_to_grant(1, 1, 2, 0, 0);
        chk("t4_final_hand_valid", hv(1), 4'b0110);
        bus_b.alloc_req = '0;
        step();
        chk("t4_quiet_after", af(1) | fl(1), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
